// File: rtl/dilithium_input_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : dilithium_input_adapter_if
// Description : Host-side and core-side beat handshake of the input adapter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dilithium_input_adapter_if;
    logic        valid_i;
    logic        ready_i;
    logic [63:0] data_i;
    logic        last_i;
    logic        core_valid_o;
    logic        core_ready_o;
    logic [63:0] core_data_o;

    // Adapter view.
    modport slave (
        input  valid_i, data_i, last_i, core_ready_o,
        output ready_i, core_valid_o, core_data_o
    );

    // Environment view (host + core).
    modport master (
        output valid_i, data_i, last_i, core_ready_o,
        input  ready_i, core_valid_o, core_data_o
    );
endinterface
`default_nettype wire

// File: rtl/dilithium_input_adapter.sv
`default_nettype none
// ============================================================================
// Module      : dilithium_input_adapter
// Description : Ingress framer; forwards host beats to the core, checks frame
//               length and last alignment, drains malformed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module dilithium_input_adapter #(
    parameter int MAX_MLEN_BYTES = 65536,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [2:0]                sec_lvl,
    dilithium_input_adapter_if.slave  bus,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FIXED = 3'd1;
    localparam logic [2:0] c_ST_MLEN  = 3'd2;
    localparam logic [2:0] c_ST_MSG   = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
    localparam logic [2:0] c_ST_ERR   = 3'd5;

    localparam logic [1:0] c_MODE_KEYGEN  = 2'd0;
    localparam logic [1:0] c_MODE_SIGN    = 2'd1;
    localparam logic [1:0] c_MODE_ILLEGAL = 2'd3;

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [2:0]       r_state, w_state_nxt, w_cont;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_fixed_words, w_msg_words;
    logic [1:0]       r_mode, w_mode_nxt;
    logic             r_err, w_err_nxt;
    logic             r_wait_last, w_wait_nxt;
    logic             w_cfg_ok, w_pass, w_xfer, w_final, w_bad_len, w_mlen_big;
    logic [31:0]      w_mlen;

    // Fixed-part word count per mode / security level.
    always_comb begin
        w_cfg_ok      = 1'b0;
        w_fixed_words = '0;
        if (mode != c_MODE_ILLEGAL) begin
            case (sec_lvl)
                3'd2: begin
                    w_cfg_ok      = 1'b1;
                    w_fixed_words = (mode == c_MODE_KEYGEN) ? CNT_W'(4) :
                                    (mode == c_MODE_SIGN)   ? CNT_W'(316) : CNT_W'(164 + 303);
                end
                3'd3: begin
                    w_cfg_ok      = 1'b1;
                    w_fixed_words = (mode == c_MODE_KEYGEN) ? CNT_W'(4) :
                                    (mode == c_MODE_SIGN)   ? CNT_W'(500) : CNT_W'(244 + 412);
                end
                3'd5: begin
                    w_cfg_ok      = 1'b1;
                    w_fixed_words = (mode == c_MODE_KEYGEN) ? CNT_W'(4) :
                                    (mode == c_MODE_SIGN)   ? CNT_W'(608) : CNT_W'(324 + 575);
                end
                default: ;
            endcase
        end
    end

    // A start cycle never consumes a beat, even mid-frame.
    assign w_pass = ((r_state == c_ST_FIXED) || (r_state == c_ST_MLEN) || (r_state == c_ST_MSG)) && !start;

    assign bus.core_valid_o = w_pass && bus.valid_i;
    assign bus.ready_i      = w_pass ? bus.core_ready_o : ((r_state == c_ST_ERR) && !start);
    assign bus.core_data_o  = bus.data_i;

    assign w_xfer      = bus.valid_i && bus.ready_i;
    assign w_mlen      = bus.data_i[31:0];
    assign w_mlen_big  = w_mlen > 32'(MAX_MLEN_BYTES);
    assign w_msg_words = CNT_W'((w_mlen + 32'd7) >> 3);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_err_nxt   = r_err;
        w_wait_nxt  = r_wait_last;
        w_final     = 1'b0;
        w_bad_len   = 1'b0;
        w_cont      = r_state;

        case (r_state)
            c_ST_FIXED: begin
                w_final = (r_cnt == c_ONE) && (r_mode == c_MODE_KEYGEN);
                w_cont  = (r_cnt == c_ONE) ? c_ST_MLEN : c_ST_FIXED;
            end
            c_ST_MLEN: begin
                w_final   = (w_mlen == 32'd0);
                w_bad_len = w_mlen_big;
                w_cont    = c_ST_MSG;
            end
            c_ST_MSG: begin
                w_final = (r_cnt == c_ONE);
            end
            default: ;
        endcase

        if (start) begin
            w_mode_nxt  = mode;
            w_cnt_nxt   = w_fixed_words;
            w_err_nxt   = !w_cfg_ok;
            w_wait_nxt  = 1'b0;
            w_state_nxt = w_cfg_ok ? c_ST_FIXED : c_ST_ERR;
        end else if (w_pass && w_xfer) begin
            w_cnt_nxt = (r_state == c_ST_MLEN) ? w_msg_words : (r_cnt - c_ONE);
            if (w_bad_len || (w_final && !bus.last_i) || (!w_final && bus.last_i)) begin
                // Wait for last only if the host has not already sent it.
                w_state_nxt = c_ST_ERR;
                w_err_nxt   = 1'b1;
                w_wait_nxt  = !bus.last_i;
            end else if (w_final) begin
                w_state_nxt = c_ST_DONE;
            end else begin
                w_state_nxt = w_cont;
            end
        end else if (r_state == c_ST_DONE) begin
            w_state_nxt = c_ST_IDLE;
        end else if ((r_state == c_ST_ERR) && (!r_wait_last || (w_xfer && bus.last_i))) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_mode      <= '0;
            r_err       <= 1'b0;
            r_wait_last <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mode      <= w_mode_nxt;
            r_err       <= w_err_nxt;
            r_wait_last <= w_wait_nxt;
        end
    end

    assign busy  = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign done  = (r_state == c_ST_DONE);
    assign error = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dilithium_input_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dilithium_input_adapter
// Description : Directed self-checking bench for the Dilithium input adapter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dilithium_input_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [2:0]  sec_lvl;
    logic        busy, done, error;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          core_xfers = 0;
    logic [63:0] core_sum = '0;
    logic        tog = 1'b0;

    dilithium_input_adapter_if bus();

    dilithium_input_adapter dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .sec_lvl (sec_lvl),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.core_valid_o && bus.core_ready_o) begin
            core_xfers = core_xfers + 1;
            core_sum   = core_sum + bus.core_data_o;
        end
    end

    // Presents one beat and holds it until accepted; checks the core-side view.
    task automatic send_beat(input logic [63:0] d, input logic l, input logic exp_cv);
        logic got;
        got = 1'b0;
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        bus.last_i  = l;
        for (int w = 0; w < 20; w++) begin
            if (tog) bus.core_ready_o = ~bus.core_ready_o;
            #1;
            if (tog) begin
                n_cmp++;
                if (bus.ready_i !== bus.core_ready_o) begin n_bad++; $display("FAIL ready_mirror: got %b want %b", bus.ready_i, bus.core_ready_o); end
            end
            if (bus.ready_i === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL ready_timeout: got ready_i=%b want 1", bus.ready_i);
        end else begin
            if (bus.core_valid_o !== exp_cv) begin n_bad++; $display("FAIL core_valid: got %b want %b", bus.core_valid_o, exp_cv); end
            if (exp_cv) begin
                n_cmp++;
                if (bus.core_data_o !== d) begin n_bad++; $display("FAIL core_data: got %h want %h", bus.core_data_o, d); end
            end
            @(negedge clk);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic [2:0] lvl);
        start = 1'b1; mode = m; sec_lvl = lvl;
        #1;
        n_cmp++;
        if (bus.ready_i !== 1'b0) begin n_bad++; $display("FAIL start_ready: got %b want 0", bus.ready_i); end
        n_cmp++;
        if (bus.core_valid_o !== 1'b0) begin n_bad++; $display("FAIL start_core_valid: got %b want 0", bus.core_valid_o); end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic host_idle();
        bus.valid_i = 1'b0; bus.last_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.valid_i = 1'b1; bus.core_ready_o = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus.ready_i !== 1'b0)      begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.ready_i); end
        n_cmp++; if (bus.core_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_core_valid: got %b want 0", bus.core_valid_o); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", error); end
        @(negedge clk);
        rst = 1'b0; bus.valid_i = 1'b0;
        @(negedge clk);
    endtask

    // Keygen frame of four beats; used both with steady and toggling core_ready.
    task automatic test_keygen(input logic [2:0] lvl, input logic [63:0] base);
        int x0; logic [63:0] s0, es, d;
        x0 = core_xfers; s0 = core_sum; es = '0;
        do_start(2'd0, lvl);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL kg_busy: got %b want 1", busy); end
        for (int i = 1; i <= 4; i++) begin
            d = base + 64'(i); es = es + d;
            send_beat(d, (i == 4), 1'b1);
        end
        host_idle();
        n_cmp++; if (done !== 1'b1)  begin n_bad++; $display("FAIL kg_done: got %b want 1", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL kg_error: got %b want 0", error); end
        n_cmp++; if (core_xfers - x0 !== 4) begin n_bad++; $display("FAIL kg_xfers: got %0d want 4", core_xfers - x0); end
        n_cmp++; if (core_sum - s0 !== es)  begin n_bad++; $display("FAIL kg_sum: got %h want %h", core_sum - s0, es); end
        @(negedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL kg_done_pulse: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL kg_idle_busy: got %b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_sign_mlen13();
        int x0;
        x0 = core_xfers;
        do_start(2'd1, 3'd3);
        for (int i = 0; i < 500; i++) send_beat({32'h5160_0000, 32'(i)}, 1'b0, 1'b1);
        send_beat(64'hFFFF_FFFF_0000_000D, 1'b0, 1'b1);
        send_beat(64'h1111_2222_3333_4444, 1'b0, 1'b1);
        send_beat(64'h5555_6666_7777_8888, 1'b1, 1'b1);
        host_idle();
        n_cmp++; if (done !== 1'b1)  begin n_bad++; $display("FAIL sign_done: got %b want 1", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL sign_error: got %b want 0", error); end
        n_cmp++; if (core_xfers - x0 !== 503) begin n_bad++; $display("FAIL sign_xfers: got %0d want 503", core_xfers - x0); end
        @(negedge clk);
    endtask

    task automatic test_verify_mlen0();
        int x0;
        x0 = core_xfers;
        do_start(2'd2, 3'd5);
        for (int i = 0; i < 899; i++) send_beat({32'hFE21_0000, 32'(i)}, 1'b0, 1'b1);
        send_beat(64'h0, 1'b1, 1'b1);
        host_idle();
        n_cmp++; if (done !== 1'b1)  begin n_bad++; $display("FAIL vfy_done: got %b want 1", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL vfy_error: got %b want 0", error); end
        n_cmp++; if (core_xfers - x0 !== 900) begin n_bad++; $display("FAIL vfy_xfers: got %0d want 900", core_xfers - x0); end
        @(negedge clk);
    endtask

    task automatic test_early_last();
        int x0;
        x0 = core_xfers;
        do_start(2'd1, 3'd2);
        for (int i = 1; i <= 100; i++) send_beat(64'(i), (i == 100), 1'b1);
        bus.valid_i = 1'b1; bus.data_i = 64'd101; bus.last_i = 1'b0;
        #1;
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL early_error: got %b want 1", error); end
        n_cmp++; if (bus.core_valid_o !== 1'b0) begin n_bad++; $display("FAIL early_core_valid: got %b want 0", bus.core_valid_o); end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL early_busy: got %b want 0", busy); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL early_sticky: got %b want 1", error); end
        n_cmp++; if (bus.core_valid_o !== 1'b0) begin n_bad++; $display("FAIL early_idle_valid: got %b want 0", bus.core_valid_o); end
        host_idle();
        n_cmp++; if (core_xfers - x0 !== 100) begin n_bad++; $display("FAIL early_xfers: got %0d want 100", core_xfers - x0); end
        @(negedge clk);
    endtask

    task automatic test_final_no_last();
        int x0;
        x0 = core_xfers;
        do_start(2'd0, 3'd5);
        for (int i = 1; i <= 4; i++) send_beat(64'hB000 + 64'(i), 1'b0, 1'b1);
        #1;
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL nolast_error: got %b want 1", error); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL nolast_done: got %b want 0", done); end
        send_beat(64'hDEAD, 1'b0, 1'b0);
        send_beat(64'hBEEF, 1'b1, 1'b0);
        host_idle();
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL nolast_busy: got %b want 0", busy); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL nolast_sticky: got %b want 1", error); end
        n_cmp++; if (core_xfers - x0 !== 4) begin n_bad++; $display("FAIL nolast_xfers: got %0d want 4", core_xfers - x0); end
        @(negedge clk);
    endtask

    task automatic test_illegal_config();
        int x0;
        x0 = core_xfers;
        bus.valid_i = 1'b1; bus.data_i = 64'h0BAD; bus.last_i = 1'b0;
        do_start(2'd0, 3'd4);
        #1;
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ill_lvl_error: got %b want 1", error); end
        n_cmp++; if (bus.core_valid_o !== 1'b0) begin n_bad++; $display("FAIL ill_core_valid: got %b want 0", bus.core_valid_o); end
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ill_busy: got %b want 0", busy); end
        do_start(2'd3, 3'd2);
        #1;
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ill_mode_error: got %b want 1", error); end
        @(negedge clk);
        host_idle();
        n_cmp++; if (core_xfers - x0 !== 0) begin n_bad++; $display("FAIL ill_xfers: got %0d want 0", core_xfers - x0); end
        do_start(2'd0, 3'd2);
        #1;
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL ill_clear: got %b want 0", error); end
        for (int i = 1; i <= 4; i++) send_beat(64'hC000 + 64'(i), (i == 4), 1'b1);
        host_idle();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ill_recover_done: got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int x0;
        x0 = core_xfers;
        do_start(2'd1, 3'd5);
        send_beat(64'hA1, 1'b0, 1'b1);
        send_beat(64'hA2, 1'b0, 1'b1);
        do_start(2'd0, 3'd2);
        for (int i = 1; i <= 4; i++) send_beat(64'hA100 + 64'(i), (i == 4), 1'b1);
        host_idle();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL abort_done: got %b want 1", done); end
        n_cmp++; if (core_xfers - x0 !== 6) begin n_bad++; $display("FAIL abort_xfers: got %0d want 6", core_xfers - x0); end
        @(negedge clk);
    endtask

    task automatic test_mlen_too_big();
        do_start(2'd1, 3'd2);
        for (int i = 0; i < 316; i++) send_beat(64'(i), 1'b0, 1'b1);
        send_beat(64'h0000_0000_0001_0001, 1'b0, 1'b1);
        host_idle();
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL big_error: got %b want 1", error); end
        n_cmp++; if (busy !== 1'b1)  begin n_bad++; $display("FAIL big_busy: got %b want 1", busy); end
        send_beat(64'hD7, 1'b1, 1'b0);
        host_idle();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL big_drained: got %b want 0", busy); end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'd0; sec_lvl = 3'd2;
        bus.valid_i = 1'b0; bus.data_i = '0; bus.last_i = 1'b0; bus.core_ready_o = 1'b1;
        @(negedge clk);
        test_reset();
        test_keygen(3'd2, 64'hA5A5_0000_0000_0000);
        test_sign_mlen13();
        test_verify_mlen0();
        test_early_last();
        test_final_no_last();
        tog = 1'b1;
        test_keygen(3'd3, 64'h7070_0000_0000_0000);
        tog = 1'b0; bus.core_ready_o = 1'b1;
        test_illegal_config();
        test_abort();
        test_mlen_too_big();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
